// File: rtl/im_port_arb.sv
// im_port_arb: arbitrates one synchronous word RAM between instruction fetch
// (reads) and the program loader (writes), with a boot phase for the loader.
// It also translates byte addresses into word indices.
//
// Ports:
//   clk, reset         clock, synchronous active-low reset
//   f_req/f_addr       fetch request and byte PC
//   f_stall            fetch not granted this cycle (combinational)
//   f_valid/f_instr    fetch response, one cycle after grant
//   l_valid/l_addr/l_data/l_ready  loader write handshake (l_ready is combinational)
//   l_done             load-complete pulse (leaves BOOT)
//   boot_busy          high while in BOOT
//   addr_err           pulse on the response cycle of a rejected access
//   mem_*              RAM macro port (combinational); mem_rdata arrives one cycle after a read
module im_port_arb #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  f_req,
    input  logic [31:0]           f_addr,
    output logic                  f_stall,
    output logic                  f_valid,
    output logic [31:0]           f_instr,
    input  logic                  l_valid,
    input  logic [31:0]           l_addr,
    input  logic [31:0]           l_data,
    output logic                  l_ready,
    input  logic                  l_done,
    output logic                  boot_busy,
    output logic                  addr_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_idx,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [CNT_W-1:0]       starve_cnt;
    logic                   f_gnt;
    logic                   l_gnt;
    logic [31:0]            f_off;
    logic [31:0]            l_off;
    logic                   f_legal;
    logic                   l_legal;
    logic [DEPTH_LOG2-1:0]  f_idx;
    logic [DEPTH_LOG2-1:0]  l_idx;
    logic                   rd_pend;
    logic [31:0]            f_hold;

    // Offset from BASE wraps modulo 2^32, so addresses below BASE are rejected by the range test.
    always_comb begin
        f_off   = f_addr - BASE_ADDR;
        l_off   = l_addr - BASE_ADDR;
        f_legal = (f_off[31:DEPTH_LOG2+2] == '0) && (f_off[1:0] == 2'b00);
        l_legal = (l_off[31:DEPTH_LOG2+2] == '0) && (l_off[1:0] == 2'b00);
        f_idx   = f_off[DEPTH_LOG2+1:2];
        l_idx   = l_off[DEPTH_LOG2+1:2];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    // Next state, grants and RAM port drive.
    always_comb begin
        next_state = state;
        f_gnt      = 1'b0;
        l_gnt      = 1'b0;
        l_ready    = 1'b0;
        boot_busy  = (state == BOOT);
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_idx    = '0;
        mem_wdata  = '0;

        if (!reset) begin
            boot_busy = 1'b1;
        end else begin
            case (state)
                BOOT: begin
                    l_ready = 1'b1;
                    l_gnt   = l_valid;
                    if (l_done) begin
                        next_state = RUN;
                    end
                end
                RUN: begin
                    // Fetch wins unless the loader has waited STARVE_MAX grants.
                    l_gnt   = l_valid && (!f_req || (starve_cnt == CNT_W'(STARVE_MAX)));
                    f_gnt   = f_req && !l_gnt;
                    l_ready = l_gnt;
                end
                default: next_state = BOOT;
            endcase
        end

        f_stall = f_req && !f_gnt;

        if (l_gnt && l_legal) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_idx   = l_idx;
            mem_wdata = l_data;
        end else if (f_gnt && f_legal) begin
            mem_en  = 1'b1;
            mem_idx = f_idx;
        end
    end

    // Response tracking, error pulse and loader starvation counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            f_valid    <= 1'b0;
            rd_pend    <= 1'b0;
            f_hold     <= '0;
            addr_err   <= 1'b0;
            starve_cnt <= '0;
        end else begin
            f_valid  <= f_gnt;
            rd_pend  <= f_gnt && f_legal;
            addr_err <= (f_gnt && !f_legal) || (l_gnt && !l_legal);

            // Keep the last delivered word so f_instr holds between responses.
            if (rd_pend) begin
                f_hold <= mem_rdata;
            end
            // A rejected fetch answers with a nop (all zeros).
            if (f_gnt && !f_legal) begin
                f_hold <= '0;
            end

            if (l_gnt || !l_valid) begin
                starve_cnt <= '0;
            end else if (f_gnt && (starve_cnt != CNT_W'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    // RAM data arrives the cycle after the read, so it is forwarded directly while pending.
    assign f_instr = rd_pend ? mem_rdata : f_hold;

endmodule

// File: tb/tb_im_port_arb.sv
// tb_im_port_arb: directed scenarios plus randomized traffic for im_port_arb,
// checked against a cycle-level reference model and a behavioural RAM.
module tb_im_port_arb;

    logic        clk;
    logic        reset;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_stall;
    logic        f_valid;
    logic [31:0] f_instr;
    logic        l_valid;
    logic [31:0] l_addr;
    logic [31:0] l_data;
    logic        l_ready;
    logic        l_done;
    logic        boot_busy;
    logic        addr_err;
    logic        mem_en;
    logic        mem_we;
    logic [11:0] mem_idx;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    im_port_arb dut (
        .clk       (clk),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_stall   (f_stall),
        .f_valid   (f_valid),
        .f_instr   (f_instr),
        .l_valid   (l_valid),
        .l_addr    (l_addr),
        .l_data    (l_data),
        .l_ready   (l_ready),
        .l_done    (l_done),
        .boot_busy (boot_busy),
        .addr_err  (addr_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_idx   (mem_idx),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous RAM macro.
    logic [31:0] ram [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
        mem_rdata = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_idx] <= mem_wdata;
            else        mem_rdata    <= ram[mem_idx];
        end
    end

    // Reference model state: word contents keyed by index, boot flag, starvation count.
    logic [31:0] mm [int];
    bit          m_boot   = 1'b1;
    int          m_starve = 0;
    bit          m_fw, m_lw, m_fl, m_ll;
    int          m_fi, m_li;

    // Expected outputs.
    bit          e_stall, e_lready, e_busy, e_men, e_mwe;
    logic [11:0] e_midx;
    logic [31:0] e_mwdata;
    bit          e_fvalid = 1'b0;
    logic [31:0] e_finstr = 32'h0;
    bit          e_aerr   = 1'b0;

    function automatic void addr_check(input logic [31:0] a, output bit legal, output int idx);
        logic [31:0] off;
        off   = a - 32'h0000_3000;
        legal = (off < 32'h0000_4000) && (off % 4 == 0);
        idx   = int'(off / 4);
    endfunction

    // Expected combinational outputs for the current inputs.
    function automatic void model_comb();
        addr_check(f_addr, m_fl, m_fi);
        addr_check(l_addr, m_ll, m_li);
        m_fw = 1'b0; m_lw = 1'b0;
        e_lready = 1'b0; e_busy = m_boot;
        e_men = 1'b0; e_mwe = 1'b0; e_midx = 12'h0; e_mwdata = 32'h0;
        if (!reset) begin
            e_busy = 1'b1;
        end else if (m_boot) begin
            e_lready = 1'b1;
            m_lw     = l_valid;
        end else begin
            m_lw     = l_valid && (!f_req || m_starve >= 4);
            m_fw     = f_req && !m_lw;
            e_lready = m_lw;
        end
        e_stall = f_req && !m_fw;
        if (m_lw && m_ll) begin
            e_men = 1'b1; e_mwe = 1'b1; e_midx = 12'(m_li); e_mwdata = l_data;
        end else if (m_fw && m_fl) begin
            e_men = 1'b1; e_midx = 12'(m_fi);
        end
    endfunction

    // Advance model state across a rising edge.
    function automatic void model_commit();
        if (!reset) begin
            m_boot = 1'b1; m_starve = 0;
            e_fvalid = 1'b0; e_finstr = 32'h0; e_aerr = 1'b0;
            return;
        end
        e_fvalid = m_fw;
        e_aerr   = (m_fw && !m_fl) || (m_lw && !m_ll);
        if (m_fw) e_finstr = m_fl ? (mm.exists(m_fi) ? mm[m_fi] : 32'h0) : 32'h0;
        if (m_lw && m_ll) mm[m_li] = l_data;
        if (m_lw || !l_valid) m_starve = 0;
        else if (m_fw && m_starve < 4) m_starve++;
        if (m_boot && l_done) m_boot = 1'b0;
    endfunction

    // Apply one cycle of inputs; returns at the falling edge with outputs settled.
    task automatic drive(input bit r, input bit fr, input logic [31:0] fa, input bit lv,
                         input logic [31:0] la, input logic [31:0] ld, input bit dn);
        reset = r; f_req = fr; f_addr = fa;
        l_valid = lv; l_addr = la; l_data = ld; l_done = dn;
        model_comb();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        drive(0, 1, 32'h3000, 1, 32'h3000, 32'hDEAD_BEEF, 0);
        checks++; if (boot_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", boot_busy); end
        checks++; if (l_ready !== 1'b0)   begin errors++; $display("FAIL reset_lready: got %b want 0", l_ready); end
        checks++; if (mem_en !== 1'b0)    begin errors++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
        checks++; if (f_stall !== 1'b1)   begin errors++; $display("FAIL reset_stall: got %b want 1", f_stall); end
        tick();
        checks++; if (f_valid !== 1'b0)   begin errors++; $display("FAIL reset_fvalid: got %b want 0", f_valid); end
        checks++; if (f_instr !== 32'h0)  begin errors++; $display("FAIL reset_finstr: got %h want 0", f_instr); end
        checks++; if (addr_err !== 1'b0)  begin errors++; $display("FAIL reset_aerr: got %b want 0", addr_err); end
        tick();
    endtask

    task automatic test_boot_load();
        drive(1, 1, 32'h3000, 1, 32'h3000, 32'h2408_0001, 0);
        checks++; if (boot_busy !== 1'b1) begin errors++; $display("FAIL boot_busy: got %b want 1", boot_busy); end
        checks++; if (f_stall !== 1'b1)   begin errors++; $display("FAIL boot_stall: got %b want 1", f_stall); end
        checks++; if (l_ready !== 1'b1 || mem_we !== 1'b1 || mem_idx !== 12'd0)
            begin errors++; $display("FAIL boot_write0: got rdy=%b we=%b idx=%0d want 1 1 0", l_ready, mem_we, mem_idx); end
        tick();
        drive(1, 1, 32'h3000, 1, 32'h3004, 32'h2409_0002, 0);
        checks++; if (f_stall !== 1'b1 || mem_idx !== 12'd1 || mem_wdata !== 32'h2409_0002)
            begin errors++; $display("FAIL boot_write1: got stall=%b idx=%0d wd=%h", f_stall, mem_idx, mem_wdata); end
        tick();
        drive(1, 0, 32'h3000, 0, 32'h0, 32'h0, 1);
        tick();
        drive(1, 1, 32'h3000, 0, 32'h0, 32'h0, 0);
        checks++; if (boot_busy !== 1'b0 || f_stall !== 1'b0 || mem_en !== 1'b1 || mem_we !== 1'b0)
            begin errors++; $display("FAIL run_fetch0: got busy=%b stall=%b en=%b we=%b", boot_busy, f_stall, mem_en, mem_we); end
        tick();
        checks++; if (f_valid !== 1'b1 || f_instr !== 32'h2408_0001)
            begin errors++; $display("FAIL fetch0_data: got v=%b %h want 1 24080001", f_valid, f_instr); end
        drive(1, 1, 32'h3004, 0, 32'h0, 32'h0, 0);
        tick();
        checks++; if (f_valid !== 1'b1 || f_instr !== 32'h2409_0002)
            begin errors++; $display("FAIL fetch1_data: got v=%b %h want 1 24090002", f_valid, f_instr); end
        drive(1, 0, 32'h3000, 0, 32'h0, 32'h0, 0);
        tick();
        checks++; if (f_valid !== 1'b0 || f_instr !== 32'h2409_0002)
            begin errors++; $display("FAIL fetch_hold: got v=%b %h want 0 24090002", f_valid, f_instr); end
    endtask

    task automatic test_done_with_write();
        drive(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        tick();
        drive(1, 0, 32'h0, 1, 32'h3010, 32'hA5A5_0010, 1);
        checks++; if (l_ready !== 1'b1 || mem_we !== 1'b1 || mem_idx !== 12'd4)
            begin errors++; $display("FAIL done_write: got rdy=%b we=%b idx=%0d want 1 1 4", l_ready, mem_we, mem_idx); end
        tick();
        drive(1, 1, 32'h3010, 0, 32'h0, 32'h0, 0);
        checks++; if (boot_busy !== 1'b0 || f_stall !== 1'b0)
            begin errors++; $display("FAIL done_run: got busy=%b stall=%b want 0 0", boot_busy, f_stall); end
        tick();
        checks++; if (f_valid !== 1'b1 || f_instr !== 32'hA5A5_0010)
            begin errors++; $display("FAIL done_readback: got v=%b %h want 1 a5a50010", f_valid, f_instr); end
    endtask

    task automatic test_starvation();
        for (int k = 0; k < 9; k++) begin
            bit want;
            want = (k == 4);
            drive(1, 1, 32'h3000, 1, 32'h3020, 32'h0000_1000 + 32'(k), 0);
            checks++; if (l_ready !== want || f_stall !== want)
                begin errors++; $display("FAIL starve_k%0d: got rdy=%b stall=%b want %b %b", k, l_ready, f_stall, want, want); end
            tick();
        end
        drive(1, 1, 32'h3020, 0, 32'h0, 32'h0, 0);
        tick();
        checks++; if (f_instr !== 32'h0000_1004)
            begin errors++; $display("FAIL starve_data: got %h want 00001004", f_instr); end
    endtask

    task automatic test_illegal_fetch();
        logic [31:0] bad [3];
        bad = '{32'h0000_2FFC, 32'h0000_7000, 32'h0000_3002};
        drive(1, 1, 32'h3000, 0, 32'h0, 32'h0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, bad[i], 0, 32'h0, 32'h0, 0);
            checks++; if (mem_en !== 1'b0 || f_stall !== 1'b0)
                begin errors++; $display("FAIL badf_port%0d: got en=%b stall=%b want 0 0", i, mem_en, f_stall); end
            tick();
            checks++; if (f_valid !== 1'b1 || f_instr !== 32'h0 || addr_err !== 1'b1)
                begin errors++; $display("FAIL badf_resp%0d: got v=%b %h err=%b want 1 0 1", i, f_valid, f_instr, addr_err); end
        end
        drive(1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        tick();
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL badf_clear: got %b want 0", addr_err); end
    endtask

    task automatic test_illegal_write();
        drive(1, 0, 32'h0, 1, 32'h7000, 32'hBAD0_BAD0, 0);
        checks++; if (l_ready !== 1'b1 || mem_en !== 1'b0)
            begin errors++; $display("FAIL badw_port: got rdy=%b en=%b want 1 0", l_ready, mem_en); end
        tick();
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL badw_err: got %b want 1", addr_err); end
        drive(1, 1, 32'h3000, 0, 32'h0, 32'h0, 0);
        tick();
        checks++; if (f_instr !== 32'h2408_0001 || addr_err !== 1'b0)
            begin errors++; $display("FAIL badw_nowrite: got %h err=%b want 24080001 0", f_instr, addr_err); end
    endtask

    task automatic test_reset_inflight();
        drive(1, 1, 32'h3004, 0, 32'h0, 32'h0, 0);
        tick();
        drive(0, 1, 32'h3004, 1, 32'h3000, 32'hFFFF_FFFF, 0);
        checks++; if (mem_en !== 1'b0 || l_ready !== 1'b0 || f_stall !== 1'b1)
            begin errors++; $display("FAIL rst_port: got en=%b rdy=%b stall=%b want 0 0 1", mem_en, l_ready, f_stall); end
        tick();
        checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL rst_discard: got %b want 0", f_valid); end
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 32'h3004, 0, 32'h0, 32'h0, (k == 2));
            checks++; if (f_stall !== 1'b1 || boot_busy !== 1'b1)
                begin errors++; $display("FAIL rst_boot%0d: got stall=%b busy=%b want 1 1", k, f_stall, boot_busy); end
            tick();
        end
        drive(1, 1, 32'h3000, 0, 32'h0, 32'h0, 0);
        checks++; if (f_stall !== 1'b0) begin errors++; $display("FAIL rst_resume: got %b want 0", f_stall); end
        tick();
        checks++; if (f_instr !== 32'h2408_0001)
            begin errors++; $display("FAIL rst_nowrite: got %h want 24080001", f_instr); end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'h0000_3000 - 32'(4 * $urandom_range(1, 4));
            1:       return 32'h0000_7000 + 32'(4 * $urandom_range(0, 3));
            2:       return 32'h0000_3000 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            3:       return 32'h0000_6FFC;
            default: return 32'h0000_3000 + 32'(4 * $urandom_range(0, 15));
        endcase
    endfunction

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            drive($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, rand_addr(),
                  $urandom_range(0, 2) == 0, rand_addr(), $urandom(), $urandom_range(0, 15) == 0);
            checks++; if (f_stall !== e_stall || l_ready !== e_lready || boot_busy !== e_busy || mem_en !== e_men)
                begin errors++; $display("FAIL rnd_comb%0d: got st=%b rdy=%b bb=%b en=%b want %b %b %b %b",
                    n, f_stall, l_ready, boot_busy, mem_en, e_stall, e_lready, e_busy, e_men); end
            if (e_men) begin
                checks++; if (mem_we !== e_mwe || mem_idx !== e_midx || (e_mwe && mem_wdata !== e_mwdata))
                    begin errors++; $display("FAIL rnd_mem%0d: got we=%b idx=%0d wd=%h want %b %0d %h",
                        n, mem_we, mem_idx, mem_wdata, e_mwe, e_midx, e_mwdata); end
            end
            tick();
            checks++; if (f_valid !== e_fvalid || f_instr !== e_finstr || addr_err !== e_aerr)
                begin errors++; $display("FAIL rnd_resp%0d: got v=%b %h err=%b want %b %h %b",
                    n, f_valid, f_instr, addr_err, e_fvalid, e_finstr, e_aerr); end
        end
    endtask

    initial begin
        reset = 1'b0; f_req = 1'b0; f_addr = 32'h0;
        l_valid = 1'b0; l_addr = 32'h0; l_data = 32'h0; l_done = 1'b0;
        test_reset();
        test_boot_load();
        test_done_with_write();
        test_starvation();
        test_illegal_fetch();
        test_illegal_write();
        test_reset_inflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
